// File: rtl/mac_wb_sequencer.sv
// mac_wb_sequencer
//   Buffers {A, B, last} samples in a small FIFO and drives a Wishbone master
//   that feeds each sample to a downstream MAC slave. For every sample it
//   writes A (+0x0) and B (+0x4), then reads +0x10 to trigger the accumulate.
//   When the sample carries the last flag, the 48-bit accumulator is read back
//   from +0x8 (low word) and +0xC (high 16 bits) and presented on r_data.
//   A transaction that sees no ACK within TIMEOUT cycles is aborted, the
//   sample is dropped and the sticky err flag is set.
//
// Ports
//   wb_clk_i, wb_rst_i             clock, async active-high reset
//   s_valid/s_ready, s_a, s_b,
//   s_last                         input sample stream
//   wbm_CYC/STB/WE/ADR/DAT_MOSI/
//   SEL, wbm_ACK, wbm_DAT_MISO     Wishbone master
//   r_valid/r_ready, r_data        accumulator readback stream
//   err                            sticky ACK-timeout flag
//
// state  | meaning
// IDLE   | waiting for a FIFO entry; pops it and launches the A write
// WR_A   | write A to BASE+0x0
// WR_B   | write B to BASE+0x4
// ACC    | read BASE+0x10 (data discarded) to accumulate
// RD_LO  | read BASE+0x8 into r_data[31:0]
// RD_HI  | read BASE+0xC into r_data[47:32]
// OUT    | r_valid held until r_ready
module mac_wb_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] BASE_ADR   = 32'h0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [24:0] s_a,
  input  logic [15:0] s_b,
  input  logic        s_last,
  output logic        wbm_CYC,
  output logic        wbm_STB,
  output logic        wbm_WE,
  output logic [31:0] wbm_ADR,
  output logic [31:0] wbm_DAT_MOSI,
  output logic        wbm_SEL,
  input  logic        wbm_ACK,
  input  logic [31:0] wbm_DAT_MISO,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [47:0] r_data,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, ACC, RD_LO, RD_HI, OUT} state_t;

  // ---------------- sample FIFO ----------------
  logic [41:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [41:0]   head;
  state_t        state_q;

  assign s_ready = (count_q != CW'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Contents need no reset: pointers and count define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {s_a, s_b, s_last};
  end

  // ---------------- sequencer FSM ----------------
  logic          gap_q;   // one idle bus cycle after every ACK
  logic [TW-1:0] tmr_q;
  logic [24:0]   a_q;
  logic [15:0]   b_q;
  logic          last_q;
  logic          cyc_q, we_q, r_valid_q, err_q;
  logic [31:0]   adr_q, dat_q;
  logic [47:0]   r_data_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      gap_q     <= 1'b0;
      tmr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            a_q     <= head[41:17];
            b_q     <= head[16:1];
            last_q  <= head[0];
            state_q <= WR_A;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= BASE_ADR;
            dat_q   <= {7'b0, head[41:17]};
            tmr_q   <= TMR_LOAD;
          end
        end
        OUT: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          if (cyc_q) begin
            if (wbm_ACK) begin
              cyc_q <= 1'b0;
              gap_q <= 1'b1;
              if (state_q == RD_LO) r_data_q[31:0]  <= wbm_DAT_MISO;
              if (state_q == RD_HI) r_data_q[47:32] <= wbm_DAT_MISO[15:0];
            end else if (tmr_q == '0) begin
              // abort: drop the sample and any pending readback
              cyc_q   <= 1'b0;
              we_q    <= 1'b0;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end else if (gap_q) begin
            gap_q <= 1'b0;
            tmr_q <= TMR_LOAD;
            we_q  <= 1'b0;
            dat_q <= '0;
            case (state_q)
              WR_A: begin
                state_q <= WR_B;
                cyc_q   <= 1'b1;
                we_q    <= 1'b1;
                adr_q   <= BASE_ADR + 32'h4;
                dat_q   <= {16'b0, b_q};
              end
              WR_B: begin
                state_q <= ACC;
                cyc_q   <= 1'b1;
                adr_q   <= BASE_ADR + 32'h10;
              end
              ACC: begin
                if (last_q) begin
                  state_q <= RD_LO;
                  cyc_q   <= 1'b1;
                  adr_q   <= BASE_ADR + 32'h8;
                end else begin
                  state_q <= IDLE;
                end
              end
              RD_LO: begin
                state_q <= RD_HI;
                cyc_q   <= 1'b1;
                adr_q   <= BASE_ADR + 32'hC;
              end
              RD_HI: begin
                state_q   <= OUT;
                r_valid_q <= 1'b1;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign wbm_CYC      = cyc_q;
  assign wbm_STB      = cyc_q;
  assign wbm_WE       = we_q;
  assign wbm_ADR      = adr_q;
  assign wbm_DAT_MOSI = dat_q;
  assign wbm_SEL      = 1'b1;
  assign r_valid      = r_valid_q;
  assign r_data       = r_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mac_wb_sequencer.sv
module tb_mac_wb_sequencer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [24:0] s_a;
  logic [15:0] s_b;
  logic        cyc, stb, we, sel, ack;
  logic [31:0] adr, mosi, miso;
  logic        r_valid, r_ready, err;
  logic [47:0] r_data;

  always #5 clk = ~clk;

  mac_wb_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(16), .BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .wbm_CYC(cyc), .wbm_STB(stb), .wbm_WE(we), .wbm_ADR(adr),
    .wbm_DAT_MOSI(mosi), .wbm_SEL(sel), .wbm_ACK(ack), .wbm_DAT_MISO(miso),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- MAC slave model (registered ACK) ----------------
  int          ack_delay = 0;
  int          wait_cnt;
  logic [24:0] m_a;
  logic [15:0] m_b;
  logic [47:0] m_acc;
  logic [31:0] s_off;
  assign s_off = adr - BASE;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0; miso <= '0; wait_cnt <= 0;
      m_a <= '0; m_b <= '0; m_acc <= '0;
    end else if (ack) begin
      ack <= 1'b0;
    end else if (cyc && stb) begin
      if (wait_cnt >= ack_delay) begin
        ack      <= 1'b1;
        wait_cnt <= 0;
        if (we) begin
          if (s_off == 32'h0) m_a <= mosi[24:0];
          if (s_off == 32'h4) m_b <= mosi[15:0];
        end else begin
          case (s_off)
            32'h10: begin m_acc <= m_acc + 48'(m_a) * 48'(m_b); miso <= 32'h0BAD_0BAD; end
            32'h8:  miso <= m_acc[31:0];
            32'hC:  begin miso <= {16'hDEAD, m_acc[47:32]}; m_acc <= '0; end
            default: miso <= 32'hFFFF_FFFF;
          endcase
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} bus_t;
  bus_t        bus_q[$];
  logic [47:0] res_q[$];

  task automatic exp_bus(input logic w, input logic [31:0] off, input logic [31:0] d);
    bus_t e;
    e.w = w; e.a = BASE + off; e.d = d;
    bus_q.push_back(e);
  endtask

  task automatic expect_sample(input logic [24:0] a, input logic [15:0] b,
                               input logic last, input logic [47:0] res);
    exp_bus(1'b1, 32'h0, {7'b0, a});
    exp_bus(1'b1, 32'h4, {16'b0, b});
    exp_bus(1'b0, 32'h10, 32'h0);
    if (last) begin
      exp_bus(1'b0, 32'h8, 32'h0);
      exp_bus(1'b0, 32'hC, 32'h0);
      res_q.push_back(res);
    end
  endtask

  logic        p_cyc, p_ack, p_we, p_hs;
  logic [31:0] p_adr, p_dat;
  int          cyc_run, last_run;

  always @(negedge clk) begin
    if (rst) begin
      p_cyc = 0; p_ack = 0; p_hs = 0; cyc_run = 0;
    end else begin
      if (p_cyc && p_ack) chk("bus_gap_after_ack", {62'b0, cyc, stb}, 64'd0);
      if (cyc && p_cyc && !p_ack) begin
        chk("adr_stable", adr, p_adr);
        chk("mosi_we_stable", {mosi, we}, {p_dat, p_we});
      end
      if (cyc && stb && ack) begin
        if (bus_q.size() == 0) chk("bus_unexpected_adr", adr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_adr", adr, e.a);
          chk("bus_we", we, e.w);
          if (e.w) chk("bus_mosi", mosi, e.d);
        end
      end
      if (p_hs) chk("r_valid_one_cycle", r_valid, 0);
      if (r_valid && r_ready) begin
        if (res_q.size() == 0) chk("res_unexpected", r_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("r_data", r_data, res_q.pop_front());
      end
      if (cyc) cyc_run++;
      else if (cyc_run != 0) begin last_run = cyc_run; cyc_run = 0; end
      p_cyc = cyc; p_ack = ack; p_we = we; p_adr = adr; p_dat = mosi;
      p_hs = r_valid && r_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [24:0] a, input logic [15:0] b, input logic last,
                      output int stalls);
    int n;
    @(negedge clk);
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    n = 0;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout_s_ready", s_ready, 1);
    stalls = n;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 400 && !(bus_q.size() == 0 && res_q.size() == 0 && !cyc && !r_valid)) begin
      @(negedge clk); n++;
    end
    chk("drain_bus_q", bus_q.size(), 0);
    chk("drain_res_q", res_q.size(), 0);
  endtask

  initial begin
    int st, n;
    rst = 1'b1; s_valid = 0; s_a = '0; s_b = '0; s_last = 0; r_ready = 1'b1;
    #1;
    chk("rst_cyc_stb_we", {61'b0, cyc, stb, we}, 64'd0);
    chk("rst_adr", adr, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rvalid_err", {62'b0, r_valid, err}, 64'd0);
    chk("rst_r_data", r_data, 0);
    chk("rst_s_ready_sel", {62'b0, s_ready, sel}, 64'd3);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single sample with readback, latency from WR_A entry to OUT
    expect_sample(25'd3, 16'd5, 1'b1, 48'd15);
    send(25'd3, 16'd5, 1'b1, st);
    idle();
    n = 0;
    while (!cyc && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!r_valid && n < 100) begin @(negedge clk); n++; end
    chk("latency_wr_a_to_out", n, 15);
    drain();
    chk("r_data_hold", r_data, 48'd15);

    // three chained samples, only the last reads back
    expect_sample(25'd2, 16'd7, 1'b0, 48'd0);
    expect_sample(25'd4, 16'd4, 1'b0, 48'd0);
    expect_sample(25'd1, 16'd1, 1'b1, 48'd31);
    send(25'd2, 16'd7, 1'b0, st); chk("s_ready_not_full_1", st, 0);
    send(25'd4, 16'd4, 1'b0, st); chk("s_ready_not_full_2", st, 0);
    send(25'd1, 16'd1, 1'b1, st); chk("s_ready_not_full_3", st, 0);
    idle();
    drain();

    // slave never acks: first sample times out, the rest still run
    ack_delay = 1000;
    expect_sample(25'd1, 16'd2, 1'b0, 48'd0);
    expect_sample(25'd3, 16'd4, 1'b0, 48'd0);
    expect_sample(25'd5, 16'd6, 1'b0, 48'd0);
    expect_sample(25'd7, 16'd8, 1'b1, 48'd100);
    send(25'd100, 16'd100, 1'b1, st);
    send(25'd1, 16'd2, 1'b0, st);
    send(25'd3, 16'd4, 1'b0, st);
    send(25'd5, 16'd6, 1'b0, st);
    send(25'd7, 16'd8, 1'b1, st);
    idle();
    chk("fifo_full_s_ready", s_ready, 0);
    n = 0;
    while (!err && n < 60) begin @(negedge clk); n++; end
    ack_delay = 0;
    chk("timeout_err", err, 1);
    chk("timeout_cyc_low", cyc, 0);
    @(negedge clk);
    chk("timeout_cyc_cycles", last_run, 16);
    drain();
    chk("err_sticky", err, 1);

    // slow slave: ACK after 5 wait cycles
    ack_delay = 5;
    expect_sample(25'd9, 16'd3, 1'b1, 48'd27);
    send(25'd9, 16'd3, 1'b1, st);
    idle();
    drain();
    ack_delay = 0;

    // reset during WR_B with three entries queued
    exp_bus(1'b1, 32'h0, 32'd11);
    send(25'd11, 16'd12, 1'b0, st);
    send(25'd13, 16'd14, 1'b0, st);
    send(25'd15, 16'd16, 1'b0, st);
    send(25'd17, 16'd18, 1'b1, st);
    idle();
    n = 0;
    while (!(cyc && adr == BASE + 32'h4) && n < 50) begin @(negedge clk); n++; end
    chk("reached_wr_b", adr, BASE + 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cyc_stb", {62'b0, cyc, stb}, 64'd0);
    chk("rst_err_clear", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_bus_q_empty", bus_q.size(), 0);
    n = 0;
    repeat (30) begin @(negedge clk); if (cyc) n++; end
    chk("no_stale_writes", n, 0);

    // extreme operands; high word must ignore MISO[31:16]
    expect_sample(25'h1FFFFFF, 16'hFFFF, 1'b1, 48'h01FF_FDFF_0001);
    send(25'h1FFFFFF, 16'hFFFF, 1'b1, st);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
